// File: rtl/j1_uart.sv
// j1_uart: memory-mapped 8N1 UART for the J1 I/O bus, with TX and RX byte FIFOs.
// Latency: reads are combinational (same cycle); uart_txd falls 1 clock after a DATA write to an idle transmitter.
// Backpressure: none on the bus; a write to a full TX FIFO is dropped, a byte received into a full RX FIFO is dropped and sets ovr.
//
// Ports:
//   sys_clk_i, sys_rst_i     clock and asynchronous active-high reset
//   io_rd, io_wr             one-cycle CPU read / write strobes
//   io_addr, io_dout         CPU address and write data
//   io_din                   read data, combinational from io_addr and state
//   uart_rxd, uart_txd       serial in (asynchronous) and serial out (idles high)
//
// Register map (offsets from BASE_ADDR, exact match only):
//   +0 DATA    read RX head (0 when empty, read pops) / write pushes TX
//   +2 STATUS  {11'h0, ferr, tx_empty, ovr, tx_full, rx_valid}; write 1 to bit 2 clears ovr, bit 4 clears ferr
//   +4 DIV     clocks per bit, values below 4 stored as 4

// Small synchronous FIFO. The caller decides when a push is legal; a pop on
// an empty FIFO is ignored. Push and pop in the same cycle on a full FIFO is
// allowed: the head is read from the old contents before the slot is reused.
module j1_uart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdat,
    input  logic         pop,
    output logic [W-1:0] rdat,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          do_pop;

    assign do_pop = pop && !empty;
    assign empty  = (cnt == '0);
    assign full   = (cnt == FULL_CNT);
    assign rdat   = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push)   wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            case ({push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdat;
    end
endmodule

module j1_uart #(
    parameter logic [15:0] BASE_ADDR  = 16'h4000,
    parameter logic [15:0] DIV_RESET  = 16'd434,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    input  logic        uart_rxd,
    output logic        uart_txd
);
    localparam logic [15:0] ADDR_DATA = BASE_ADDR;
    localparam logic [15:0] ADDR_STAT = BASE_ADDR + 16'd2;
    localparam logic [15:0] ADDR_DIV  = BASE_ADDR + 16'd4;
    localparam logic [15:0] DIV_MIN   = 16'd4;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic sel_data, sel_stat, sel_div;
    assign sel_data = (io_addr == ADDR_DATA);
    assign sel_stat = (io_addr == ADDR_STAT);
    assign sel_div  = (io_addr == ADDR_DIV);

    logic [15:0] div;
    logic        ovr, ferr, ferr_set;

    // ---------------- FIFOs ----------------
    logic       tx_push, tx_pop, tx_fempty, tx_full;
    logic [7:0] tx_head;
    logic       rx_push_req, rx_push, rx_pop, rx_empty, rx_full;
    logic [7:0] rx_head;
    logic [7:0] rx_sh, rx_sh_n;

    assign tx_push = io_wr && sel_data && !tx_full;
    assign rx_pop  = io_rd && sel_data && !rx_empty;
    // A pop in the same cycle frees the slot, so a full RX FIFO still accepts.
    assign rx_push = rx_push_req && (!rx_full || rx_pop);

    j1_uart_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(sys_clk_i), .rst(sys_rst_i),
        .push(tx_push), .wdat(io_dout[7:0]), .pop(tx_pop),
        .rdat(tx_head), .empty(tx_fempty), .full(tx_full)
    );

    j1_uart_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(sys_clk_i), .rst(sys_rst_i),
        .push(rx_push), .wdat(rx_sh), .pop(rx_pop),
        .rdat(rx_head), .empty(rx_empty), .full(rx_full)
    );

    // ---------------- divisor and sticky flags ----------------
    // A flag set in the same cycle as its clear wins.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            div  <= DIV_RESET;
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            if (io_wr && sel_div) div <= (io_dout < DIV_MIN) ? DIV_MIN : io_dout;
            if (rx_push_req && rx_full && !rx_pop)    ovr <= 1'b1;
            else if (io_wr && sel_stat && io_dout[2]) ovr <= 1'b0;
            if (ferr_set)                             ferr <= 1'b1;
            else if (io_wr && sel_stat && io_dout[4]) ferr <= 1'b0;
        end
    end

    // ---------------- TX FSM ----------------
    state_t      tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [7:0]  tx_sh, tx_sh_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic        txd_q, txd_n, tx_load;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_div   <= DIV_RESET;
            tx_sh    <= '0;
            tx_bit   <= '0;
            txd_q    <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_div   <= tx_div_n;
            tx_sh    <= tx_sh_n;
            tx_bit   <= tx_bit_n;
            txd_q    <= txd_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_div_n   = tx_div;
        tx_sh_n    = tx_sh;
        tx_bit_n   = tx_bit;
        txd_n      = txd_q;
        tx_load    = 1'b0;
        case (tx_state)
            S_IDLE: tx_load = !tx_fempty;
            S_START: begin
                if (tx_cnt == 16'd0) begin
                    tx_state_n = S_DATA;
                    tx_cnt_n   = tx_div - 16'd1;
                    tx_bit_n   = 3'd0;
                    txd_n      = tx_sh[0];
                end else tx_cnt_n = tx_cnt - 16'd1;
            end
            S_DATA: begin
                if (tx_cnt == 16'd0) begin
                    tx_cnt_n = tx_div - 16'd1;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = S_STOP;
                        txd_n      = 1'b1;
                    end else begin
                        tx_bit_n = tx_bit + 3'd1;
                        tx_sh_n  = tx_sh >> 1;
                        txd_n    = tx_sh[1];
                    end
                end else tx_cnt_n = tx_cnt - 16'd1;
            end
            S_STOP: begin
                if (tx_cnt == 16'd0) begin
                    tx_state_n = S_IDLE;
                    // Chain straight into the next start bit: no idle gap.
                    tx_load    = !tx_fempty;
                end else tx_cnt_n = tx_cnt - 16'd1;
            end
        endcase
        if (tx_load) begin
            tx_state_n = S_START;
            tx_sh_n    = tx_head;
            tx_div_n   = div;
            tx_cnt_n   = div - 16'd1;
            txd_n      = 1'b0;
        end
    end

    assign tx_pop   = tx_load;
    assign uart_txd = txd_q;

    // ---------------- RX synchroniser and FSM ----------------
    logic        rx_meta, rx_sync;
    state_t      rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
    logic [2:0]  rx_bit, rx_bit_n;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_div   <= DIV_RESET;
            rx_sh    <= '0;
            rx_bit   <= '0;
        end else begin
            rx_meta  <= uart_rxd;
            rx_sync  <= rx_meta;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_div   <= rx_div_n;
            rx_sh    <= rx_sh_n;
            rx_bit   <= rx_bit_n;
        end
    end

    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_div_n    = rx_div;
        rx_sh_n     = rx_sh;
        rx_bit_n    = rx_bit;
        rx_push_req = 1'b0;
        ferr_set    = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (!rx_sync) begin
                    // Wait half a bit so later samples land mid-bit.
                    rx_state_n = S_START;
                    rx_div_n   = div;
                    rx_cnt_n   = (div >> 1) - 16'd1;
                end
            end
            S_START: begin
                if (rx_cnt == 16'd0) begin
                    if (rx_sync) rx_state_n = S_IDLE;
                    else begin
                        rx_state_n = S_DATA;
                        rx_cnt_n   = rx_div - 16'd1;
                        rx_bit_n   = 3'd0;
                    end
                end else rx_cnt_n = rx_cnt - 16'd1;
            end
            S_DATA: begin
                if (rx_cnt == 16'd0) begin
                    rx_sh_n  = {rx_sync, rx_sh[7:1]};
                    rx_cnt_n = rx_div - 16'd1;
                    rx_bit_n = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_n = S_STOP;
                end else rx_cnt_n = rx_cnt - 16'd1;
            end
            S_STOP: begin
                if (rx_cnt == 16'd0) begin
                    rx_state_n = S_IDLE;
                    if (rx_sync) rx_push_req = 1'b1;
                    else         ferr_set    = 1'b1;
                end else rx_cnt_n = rx_cnt - 16'd1;
            end
        endcase
    end

    // ---------------- read mux ----------------
    // tx_empty is masked during reset so STATUS reads zero while reset is held.
    logic tx_empty;
    assign tx_empty = tx_fempty && (tx_state == S_IDLE) && !sys_rst_i;

    always_comb begin
        io_din = 16'h0;
        if (sel_data)      io_din = rx_empty ? 16'h0 : {8'h0, rx_head};
        else if (sel_stat) io_din = {11'h0, ferr, tx_empty, ovr, tx_full, !rx_empty};
        else if (sel_div)  io_din = div;
    end
endmodule

// File: tb/tb_j1_uart.sv
`timescale 1ns/1ps
module tb_j1_uart;
    localparam logic [15:0] A_DATA = 16'h4000;
    localparam logic [15:0] A_STAT = 16'h4002;
    localparam logic [15:0] A_DIV  = 16'h4004;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_rd = 1'b0, io_wr = 1'b0;
    logic [15:0] io_addr = 16'h0, io_dout = 16'h0;
    logic [15:0] io_din;
    logic        rxd = 1'b1;
    logic        txd;

    j1_uart dut (
        .sys_clk_i(clk), .sys_rst_i(rst),
        .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr), .io_dout(io_dout),
        .io_din(io_din), .uart_rxd(rxd), .uart_txd(txd)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, cyc = 0;
    always @(posedge clk) cyc++;

    // Reference model state
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [15:0] rdq[$];
    string       rdn[$];
    int          start_cyc[$];
    logic        m_ovr = 1'b0, m_ferr = 1'b0;
    int          mdiv = 434;
    int          tx_pending = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] st_exp(input logic txe, input logic txf);
        return {11'h0, m_ferr, txe, m_ovr, txf, (rxq.size() != 0)};
    endfunction

    // Read monitor: compares io_din whenever the CPU strobes a read.
    always @(negedge clk) begin
        if (io_rd) begin
            if (rdq.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL rd_noexp: got %h expected nothing", io_din);
            end else check(rdn.pop_front(), io_din, rdq.pop_front());
        end
    end

    // TX monitor: decodes frames at mid-bit and checks them against txq.
    bit         tm_act = 0;
    int         tm_cnt = 0, tm_div = 4;
    logic [9:0] tm_bits;
    always @(negedge clk) begin
        if (rst) tm_act = 0;
        else if (!tm_act) begin
            if (txd === 1'b0) begin
                tm_act = 1; tm_cnt = 0; tm_div = mdiv; tm_bits = '0;
                start_cyc.push_back(cyc);
            end
        end else begin
            tm_cnt++;
            if (tm_cnt % tm_div == tm_div / 2) begin
                tm_bits[tm_cnt / tm_div] = txd;
                if (tm_cnt / tm_div == 9) begin
                    tm_act = 0;
                    if (txq.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL tx_unexpected: got frame %b expected none", tm_bits);
                    end else check("tx_frame", {6'h0, tm_bits}, {6'h0, 1'b1, txq.pop_front(), 1'b0});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_rd(input logic [15:0] a, input logic [15:0] exp, input string nm);
        io_addr = a; io_rd = 1'b1;
        rdq.push_back(exp); rdn.push_back(nm);
        @(posedge clk); #1;
        io_rd = 1'b0;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        io_addr = a; io_dout = d; io_wr = 1'b1;
        @(posedge clk); #1;
        io_wr = 1'b0;
    endtask

    task automatic read_data(input string nm);
        logic [15:0] e;
        e = (rxq.size() != 0) ? {8'h0, rxq.pop_front()} : 16'h0;
        bus_rd(A_DATA, e, nm);
    endtask

    // From idle the shifter takes one byte and the FIFO holds DEPTH more.
    task automatic cpu_tx(input logic [7:0] b);
        bus_wr(A_DATA, {8'($urandom), b});
        if (tx_pending < DEPTH + 1) begin
            txq.push_back(b);
            tx_pending++;
        end
    endtask

    task automatic set_div(input logic [15:0] v);
        bus_wr(A_DIV, v);
        mdiv = (v < 16'd4) ? 4 : int'(v);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic sb);
        logic [9:0] f;
        f = {sb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            tick(mdiv);
        end
        rxd = 1'b1;
        if (sb) begin
            if (rxq.size() < DEPTH) rxq.push_back(b);
            else m_ovr = 1'b1;
        end else m_ferr = 1'b1;
    endtask

    task automatic tx_wait_idle(input string nm);
        tick(10 * mdiv * tx_pending + 4 * mdiv + 10);
        check(nm, 16'(txq.size()), 16'h0);
        tx_pending = 0;
        bus_rd(A_STAT, st_exp(1'b1, 1'b0), {nm, "_stat"});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] f1;
        int ok, n;
        logic [7:0] b;

        // Reset state, read while reset is held
        tick(2);
        check("rst_txd", {15'h0, txd}, 16'h1);
        bus_rd(A_DIV, 16'd434, "rst_div");
        bus_rd(A_STAT, 16'h0, "rst_stat");
        bus_rd(A_DATA, 16'h0, "rst_data");
        rst = 1'b0;
        tick(2);
        bus_rd(A_STAT, st_exp(1'b1, 1'b0), "post_rst_stat");
        bus_rd(16'h4006, 16'h0, "unmapped_rd");
        bus_wr(16'h4005, 16'h0009);
        bus_rd(A_DIV, 16'd434, "unmapped_wr");

        // 1: 0x55 frame at DIV=4, bit-exact line check
        set_div(16'd4);
        bus_rd(A_DIV, 16'd4, "t1_div");
        f1 = 10'b1_01010101_0;
        cpu_tx(8'h55);
        tick(1);
        for (int i = 0; i < 40; i++) begin
            check("t1_txd", {15'h0, txd}, {15'h0, f1[i / 4]});
            if (i == 39) bus_rd(A_STAT, st_exp(1'b0, 1'b0), "t1_busy");
            else tick(1);
        end
        bus_rd(A_STAT, st_exp(1'b1, 1'b0), "t1_idle");
        tx_pending = 0;

        // 2: receive 0xA5
        send_rx(8'hA5, 1'b1);
        tick(mdiv + 4);
        bus_rd(A_STAT, 16'h0009, "t2_stat");
        read_data("t2_data");
        read_data("t2_data_empty");
        bus_rd(A_STAT, st_exp(1'b1, 1'b0), "t2_stat_after");

        // 3: overrun with 9 received bytes
        for (int i = 0; i < 9; i++) send_rx(8'(i), 1'b1);
        tick(mdiv + 4);
        bus_rd(A_STAT, 16'h000D, "t3_ovr");
        for (int i = 0; i < 9; i++) read_data("t3_data");
        bus_rd(A_STAT, st_exp(1'b1, 1'b0), "t3_stat");
        bus_wr(A_STAT, 16'h0004);
        m_ovr = 1'b0;
        bus_rd(A_STAT, 16'h0008, "t3_clr");

        // 4: 10 back-to-back writes, 10th dropped, no gap between frames
        start_cyc.delete();
        for (int i = 0; i < 9; i++) cpu_tx(8'h30 + 8'(i));
        bus_rd(A_STAT, st_exp(1'b0, 1'b1), "t4_full");
        cpu_tx(8'hEE);
        tx_wait_idle("t4_drain");
        check("t4_nframes", 16'(start_cyc.size()), 16'd9);
        ok = 1;
        for (int i = 1; i < start_cyc.size(); i++)
            if (start_cyc[i] - start_cyc[i-1] != 10 * mdiv) ok = 0;
        check("t4_gap", 16'(ok), 16'd1);

        // 5: framing error, then a glitch that must be ignored
        send_rx(8'h3C, 1'b0);
        tick(mdiv + 4);
        bus_rd(A_STAT, 16'h0018, "t5_ferr");
        rxd = 1'b0; tick(1); rxd = 1'b1;
        tick(mdiv / 2 + 6);
        bus_rd(A_STAT, 16'h0018, "t5_glitch");
        read_data("t5_data");
        bus_wr(A_STAT, 16'h0010);
        m_ferr = 1'b0;
        bus_rd(A_STAT, 16'h0008, "t5_clr");

        // 6: reset in the middle of a TX frame
        cpu_tx(8'h00);
        tick(10);
        check("t6_busy_txd", {15'h0, txd}, 16'h0);
        rst = 1'b1;
        #1;
        check("t6_txd", {15'h0, txd}, 16'h1);
        txq.delete(); rxq.delete(); tx_pending = 0;
        m_ovr = 1'b0; m_ferr = 1'b0; mdiv = 434;
        bus_rd(A_DIV, 16'd434, "t6_div");
        bus_rd(A_STAT, 16'h0, "t6_stat");
        rst = 1'b0;
        tick(2);
        set_div(16'h0002);
        bus_rd(A_DIV, 16'h0004, "t6_div_min");
        set_div(16'h0005);
        bus_rd(A_DIV, 16'h0005, "t6_div5");

        // Randomized traffic against the model
        for (int it = 0; it < 12; it++) begin
            set_div(16'($urandom_range(4, 9)));
            n = $urandom_range(1, 10);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                send_rx(b, ($urandom_range(0, 7) != 0));
            end
            tick(mdiv + 4);
            bus_rd(A_STAT, st_exp(1'b1, 1'b0), "rnd_rx_stat");
            n = rxq.size();
            for (int k = 0; k <= n; k++) read_data("rnd_rx_data");
            bus_wr(A_STAT, 16'h0014);
            m_ovr = 1'b0; m_ferr = 1'b0;
            bus_rd(A_STAT, 16'h0008, "rnd_clr");
            n = $urandom_range(1, 11);
            for (int k = 0; k < n; k++) cpu_tx(8'($urandom));
            tx_wait_idle("rnd_tx_drain");
        end

        tick(4);
        check("rdq_empty", 16'(rdq.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
